// File: rtl/spi_master_pad_arbiter_pkg.sv
// spi_arb_pkg: shared types, mode codes and OE decode for the SPI pad arbiter.
package spi_arb_pkg;
  localparam logic [1:0] SPI_MODE_STD = 2'd0;
  localparam logic [1:0] SPI_MODE_QUAD_TX = 2'd1;
  localparam logic [1:0] SPI_MODE_QUAD_RX = 2'd2;
  localparam logic [3:0] CSN_IDLE = 4'hF;
  typedef enum logic [1:0] {IDLE, BUSY, GAP} arb_state_t;
  function automatic logic [3:0] oe_decode(input logic [1:0] mode);
    return {{3{mode == SPI_MODE_QUAD_TX}}, (mode == SPI_MODE_STD) || (mode == SPI_MODE_QUAD_TX)};
  endfunction
endpackage

// File: rtl/spi_master_pad_arbiter_rr_pick.sv
// spi_rr_pick: combinational round-robin picker, first requester after last.
module spi_rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_i,
  output logic                 vld_o,
  output logic [$clog2(N)-1:0] idx_o
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] cand;
  // Walk from farthest to nearest so the nearest hit after last wins.
  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    cand = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(last_i) + k) % N);
      if (req_i[cand]) begin
        vld_o = 1'b1;
        idx_o = cand;
      end
    end
  end
endmodule

// File: rtl/spi_master_pad_arbiter.sv
// spi_master_pad_arbiter: shares one quad-SPI pad set between N_REQ masters with
// transaction-atomic round-robin grants, an idle gap between owners and a watchdog.
module spi_master_pad_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT = 65535,
  parameter int TO_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_i,
  output logic [N_REQ-1:0]         gnt_o,
  input  logic [N_REQ-1:0]         m_clk_i,
  input  logic [4*N_REQ-1:0]       m_csn_i,
  input  logic [2*N_REQ-1:0]       m_mode_i,
  input  logic [4*N_REQ-1:0]       m_sdo_i,
  output logic [4*N_REQ-1:0]       m_sdi_o,
  output logic                     pad_clk_o,
  output logic [3:0]               pad_csn_o,
  output logic [3:0]               pad_sdo_o,
  output logic [3:0]               pad_oe_o,
  input  logic [3:0]               pad_sdi_i,
  output logic                     timeout_o,
  output logic [$clog2(N_REQ)-1:0] timeout_id_o
);
  localparam int IW = $clog2(N_REQ);
  localparam int DW = 4 * N_REQ;
  localparam arb_state_t REL_ST = (GAP_CYCLES == 0) ? IDLE : GAP;
  arb_state_t state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, last_q, last_d, to_id_q, to_id_d, pick_idx;
  logic [N_REQ-1:0] gnt_q, gnt_d, lock_q, lock_d, to_set;
  logic [TO_W-1:0] wd_q, wd_d;
  logic [15:0] gap_q, gap_d;
  logic to_q, to_d, pick_vld, busy, own_req, release_c, expire;
  logic [3:0] own_csn;
  logic [1:0] own_mode;
  spi_rr_pick #(.N(N_REQ)) u_pick (
    .req_i (req_i & ~lock_q),
    .last_i(last_q),
    .vld_o (pick_vld),
    .idx_o (pick_idx)
  );
  assign busy = state_q == BUSY;
  assign own_req = req_i[owner_q];
  assign own_csn = 4'(m_csn_i >> (4 * owner_q));
  assign own_mode = 2'(m_mode_i >> (2 * owner_q));
  assign release_c = busy && !own_req && (own_csn == CSN_IDLE);
  // A clean release in the expiry cycle takes priority over the watchdog.
  assign expire = busy && !release_c && (TIMEOUT != 0) && (wd_q == TO_W'(TIMEOUT));
  assign lock_d = (lock_q & req_i) | to_set;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d = last_q;
    gnt_d = gnt_q;
    wd_d = wd_q;
    gap_d = gap_q;
    to_d = 1'b0;
    to_id_d = to_id_q;
    to_set = '0;
    case (state_q)
      IDLE: if (pick_vld) begin
        state_d = BUSY;
        owner_d = pick_idx;
        last_d = pick_idx;
        gnt_d = N_REQ'(1) << pick_idx;
        wd_d = TO_W'(1);
      end
      BUSY: if (release_c || expire) begin
        state_d = REL_ST;
        gnt_d = '0;
        gap_d = '0;
        to_d = expire;
        to_id_d = expire ? owner_q : to_id_q;
        to_set = expire ? N_REQ'(1) << owner_q : '0;
      end else wd_d = wd_q + 1'b1;
      GAP: if (gap_q == 16'(GAP_CYCLES - 1)) state_d = IDLE;
        else gap_d = gap_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q <= IW'(N_REQ - 1);
      gnt_q <= '0;
      lock_q <= '0;
      wd_q <= '0;
      gap_q <= '0;
      to_q <= 1'b0;
      to_id_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      gnt_q <= gnt_d;
      lock_q <= lock_d;
      wd_q <= wd_d;
      gap_q <= gap_d;
      to_q <= to_d;
      to_id_q <= to_id_d;
    end
  end
  assign gnt_o = gnt_q;
  assign timeout_o = to_q;
  assign timeout_id_o = to_id_q;
  assign pad_clk_o = busy & m_clk_i[owner_q];
  assign pad_csn_o = busy ? own_csn : CSN_IDLE;
  assign pad_sdo_o = busy ? 4'(m_sdo_i >> (4 * owner_q)) : 4'h0;
  assign pad_oe_o = busy ? oe_decode(own_mode) : 4'h0;
  assign m_sdi_o = busy ? DW'(pad_sdi_i) << (4 * owner_q) : '0;
endmodule

// File: doc/spi_master_pad_arbiter.md
Name: spi_master_pad_arbiter

Overview:
- Shares the single quad-SPI master pad set (clock, 4 chip selects, 4 bidirectional data lines) between N_REQ SPI master engines.
- Requester 0 is the PULPino SoC SPI master, gated by a software-driven GPIO request bit. Requester 1 is the Ethernet-side SPI DMA engine.
- Grants are transaction-atomic, round-robin, with an enforced idle gap between owners and a watchdog timeout.
- Sits in the FPGA top between the masters and the pad tristate logic, and produces the per-line output enables.

Parameters:
- N_REQ, 2, number of SPI masters sharing the pads (2..4).
- GAP_CYCLES, 4, idle cycles with all CS high between owners (0 = no gap).
- TIMEOUT, 65535, maximum cycles one grant may last (0 = watchdog disabled).
- TO_W, 16, width of the watchdog counter; TIMEOUT must be < 2**TO_W.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- req_i  in  N_REQ  per-master request; held high for the whole transaction.
- gnt_o  out  N_REQ  registered one-hot grant.
- m_clk_i  in  N_REQ  per-master SPI clock.
- m_csn_i  in  4*N_REQ  per-master chip selects, active low; master r uses bits [4r+3:4r].
- m_mode_i  in  2*N_REQ  per-master mode: 0 STD, 1 QUAD_TX, 2 QUAD_RX.
- m_sdo_i  in  4*N_REQ  per-master serial data out.
- m_sdi_o  out  4*N_REQ  per-master serial data in.
- pad_clk_o  out  1  SPI clock to pad.
- pad_csn_o  out  4  chip selects to pad.
- pad_sdo_o  out  4  data to pad.
- pad_oe_o  out  4  per-line output enable, 1 = drive.
- pad_sdi_i  in  4  data from pad.
- timeout_o  out  1  one-cycle pulse when the watchdog revokes a grant.
- timeout_id_o  out  $clog2(N_REQ)  index of the revoked owner; valid with timeout_o and held until the next timeout.

Behaviour:
- State machine, states IDLE, BUSY, GAP. Registered state: owner index, round-robin pointer last, watchdog count, gap count.
- Reset values:
  - state = IDLE, gnt_o = 0, last = N_REQ-1 (so master 0 wins first), counters = 0.
  - timeout_o = 0, timeout_id_o = 0.
  - pad_csn_o = 4'hF, pad_clk_o = 0, pad_sdo_o = 0, pad_oe_o = 0, all m_sdi_o = 0.
- Reset mid-transaction: pads return to the idle values in the cycle after rst is sampled. No gap is enforced after reset.
- IDLE:
  - Pads are at idle values.
  - If any req_i is high, pick the first requester at or after last+1 (mod N_REQ). Register owner and last, set gnt_o[owner], and go to BUSY.
  - Latency: req_i sampled high in cycle t gives gnt_o and pad mux switched in cycle t+1.
- BUSY:
  - Pads are driven from the owner combinationally off the registered owner: pad_clk_o, pad_csn_o, pad_sdo_o.
  - m_sdi_o[owner] = pad_sdi_i; all other masters see 0.
  - pad_oe_o[0] = 1 when owner mode is STD or QUAD_TX.
  - pad_oe_o[3:1] = 4'b111 slice when owner mode is QUAD_TX, else 0.
  - Mode 3 is treated as QUAD_RX (no drive).
  - Release condition: owner req_i = 0 AND owner csn = 4'hF, evaluated in the same cycle.
    - A req drop while any CS is low does not release; the transaction completes first.
    - On release: gnt_o = 0 next cycle, then GAP (or IDLE if GAP_CYCLES = 0).
  - Watchdog (TIMEOUT != 0):
    - Counts cycles in BUSY from 1.
    - When count = TIMEOUT and no release has occurred, force release. Pulse timeout_o, load timeout_id_o = owner, and clear gnt_o.
    - Pads go idle next cycle regardless of CS.
    - The revoked master must drop req_i before it can be regranted.
  - Non-owner requests are ignored while BUSY. Their gnt_o stays 0 and their outputs never reach the pads.
- GAP:
  - Pads at idle values for exactly GAP_CYCLES cycles, then IDLE.
  - IDLE may grant in its first cycle, so the pad idle time between owners is GAP_CYCLES+1 cycles.
- Simultaneous events:
  - Owner release and another request in the same cycle: GAP first, then grant.
  - Watchdog expiry and normal release in the same cycle: normal release wins; no timeout pulse.
- Revoked-owner lockout: a 1-bit-per-master register, set on timeout and cleared when that req_i is low. A locked master is excluded from the pick.
- Fairness: with all masters requesting continuously, grant order cycles 0,1,...,N_REQ-1.

Decomposition:
- Package spi_arb_pkg:
  - mode constants SPI_MODE_STD = 0, SPI_MODE_QUAD_TX = 1, SPI_MODE_QUAD_RX = 2;
  - state enum arb_state_t {IDLE, BUSY, GAP};
  - CSN_IDLE = 4'hF.
- Sub-module spi_rr_pick: combinational round-robin picker. Inputs: request vector (already masked by lockout) and last. Outputs: valid and index.
- Everything else, including the pad mux and OE decode, stays in the top module.

Test Plan:
- Reset, then req_i = 2'b11 held: gnt_o = 2'b01 one cycle after sampling. Master 1 is granted only after master 0 drops req with CS high, and gnt_o[1] rises 5 cycles after gnt_o[0] falls (GAP_CYCLES = 4). Check pad_csn_o = F throughout the gap.
- Master 0 owns in mode QUAD_TX, then STD, then QUAD_RX: pad_oe_o = F, then 1, then 0. pad_sdi_i = 4'hA gives m_sdi_o[3:0] = A and m_sdi_o[7:4] = 0.
- Master 0 drops req_i while m_csn_i[0] = 0: grant held. CS goes high 10 cycles later and release happens in that cycle; gnt_o falls on the next cycle.
- TIMEOUT = 20: master 1 holds req with CS low. After 20 BUSY cycles, timeout_o pulses with timeout_id_o = 1, pads go idle, and master 1 is not regranted until its req toggles low.
- Assert rst while master 1 owns mid-byte: the next cycle shows pads idle and gnt_o = 0. After rst deasserts with both requesting, master 0 is granted first.
